prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/prog_clock_divider_if.sv | 30 +++
 rtl/clkdiv_channel.sv | 58 +++++
 rtl/prog_clock_divider.sv | 67 ++++++
 tb/tb_prog_clock_divider.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the programmable clock divider.
package clkdiv_pkg;

    localparam int unsigned NCH_DEF         = 4;
    localparam int unsigned DIV_W_DEF       = 16;
    localparam int unsigned DEFAULT_DIV_DEF = 2000;

    // High time of a period of n cycles: odd periods spend the extra cycle high.
    function automatic logic [31:0] half_period(input logic [31:0] n);
        logic [32:0] sum;
        sum = 33'(n) + 33'd1;
        return 32'(sum >> 1);
    endfunction

endpackage

// File: rtl/prog_clock_divider_if.sv
// Divisor-update handshake between a configuration master and the divider.
interface prog_clock_divider_if
    import clkdiv_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
);

    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, staged (shadow) divisor and registered outputs.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] high_time;
    logic             run;
    logic             wrap;
    logic             apply;

    // A staged divisor only lands on a period boundary, so no period is ever cut short.
    always_comb begin
        high_time = DIV_W'(half_period(32'(div)));
        run       = en && (div != '0);
        wrap      = run && (cnt == div - DIV_W'(1));
        apply     = pending && (sync || wrap || !run);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            div     <= DIV_W'(DEFAULT_DIV);
            shadow  <= DIV_W'(DEFAULT_DIV);
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            clk_out <= run && (cnt < high_time);
            tick    <= run && (cnt == '0);
            cnt     <= (run && !wrap && !sync) ? cnt + DIV_W'(1) : '0;
            // load requires !pending and apply requires pending, so they never collide
            if (apply) begin
                div     <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                shadow  <= load_div;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// Optional CLKDIV_SYNC_START_EN adds a sync_start input that phase-aligns all channels.
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int unsigned NCH         = NCH_DEF,
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCH-1:0]             en,
`ifdef CLKDIV_SYNC_START_EN
    input  logic                       sync_start,
`endif
    prog_clock_divider_if.slave        cfg,
    output logic [NCH-1:0]             clk_out,
    output logic [NCH-1:0]             tick,
    output logic [NCH-1:0]             pending
);

    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic           sync;
    logic           ready;
    logic [NCH-1:0] load;

`ifdef CLKDIV_SYNC_START_EN
    assign sync = sync_start;
`else
    assign sync = 1'b0;
`endif

    // Channel select decode; an out-of-range channel matches nothing and stays not-ready.
    always_comb begin
        ready = 1'b0;
        load  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                ready = !pending[i];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            load[i] = cfg.cfg_valid && ready && (cfg.cfg_ch == CH_W'(i));
        end
    end

    assign cfg.cfg_ready = ready;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkdiv_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en[g]),
            .sync     (sync),
            .load     (load[g]),
            .load_div (cfg.cfg_div),
            .clk_out  (clk_out[g]),
            .tick     (tick[g]),
            .pending  (pending[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: a phase-based reference predicts clk_out/tick per cycle.
module tb_prog_clock_divider;

    localparam int unsigned NCH     = 3;
    localparam int unsigned DIV_W   = 16;
    localparam int unsigned DEF_DIV = 10;
    localparam int unsigned CH_W    = 2;

    typedef struct {
        logic [NCH-1:0] co;
        logic [NCH-1:0] tk;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] en;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;
`ifdef CLKDIV_SYNC_START_EN
    logic           sync_start;
`endif

    prog_clock_divider_if #(.NCH(NCH), .DIV_W(DIV_W)) cfg_if ();

    prog_clock_divider #(
        .NCH         (NCH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
`ifdef CLKDIV_SYNC_START_EN
        .sync_start (sync_start),
`endif
        .cfg        (cfg_if),
        .clk_out    (clk_out),
        .tick       (tick),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    int   div_m[NCH];
    int   ph_m[NCH];
    bit   en_m[NCH];

    // Advance to the next sampling point (one rising edge later).
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_en(input int ch, input bit v);
        en[ch]   = v;
        en_m[ch] = v;
    endtask

    task automatic disable_all();
        en = '0;
        for (int i = 0; i < NCH; i++) begin
            en_m[i] = 1'b0;
            ph_m[i] = 0;
        end
        cyc();
    endtask

    // Stage and apply a divisor on a channel that is not running.
    task automatic setdiv(input int ch, input int n);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = CH_W'(ch);
        cfg_if.cfg_div   = DIV_W'(n);
        cyc();
        cfg_if.cfg_valid = 1'b0;
        cyc();
        div_m[ch] = n;
        ph_m[ch]  = 0;
    endtask

    // Predict the next sample from each channel's position within its period.
    task automatic push_step();
        exp_t e;
        e.co = '0;
        e.tk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (en_m[i] && div_m[i] > 0) begin
                e.co[i] = (ph_m[i] < (div_m[i] + 1) / 2);
                e.tk[i] = (ph_m[i] == 0);
                ph_m[i] = (ph_m[i] + 1) % div_m[i];
            end else begin
                ph_m[i] = 0;
            end
        end
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = '0;
        cyc();
        cyc();
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs clk_out=%b tick=%b expected 000 000", clk_out, tick);
        end
        checks++;
        if (pending !== 3'b000) begin
            failures++;
            $display("FAIL reset_pending pending=%b expected 000", pending);
        end
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready cfg_ready=%b expected 1", cfg_if.cfg_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            div_m[i] = DEF_DIV;
            ph_m[i]  = 0;
            en_m[i]  = 1'b0;
        end
        cyc();
    endtask

    task automatic test_cfg_boundary();
        cfg_if.cfg_ch    = CH_W'(3);
        cfg_if.cfg_div   = DIV_W'(7);
        cfg_if.cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL ch_out_of_range cfg_ready=%b expected 0", cfg_if.cfg_ready);
        end
        cyc();
        cfg_if.cfg_valid = 1'b0;
        cyc();
        checks++;
        if (pending !== 3'b000) begin
            failures++;
            $display("FAIL ch_out_of_range_pending pending=%b expected 000", pending);
        end
        cfg_if.cfg_ch = CH_W'(2);
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL ch_last_ready cfg_ready=%b expected 1", cfg_if.cfg_ready);
        end
    endtask

    task automatic test_basic_n4();
        exp_t e;
        disable_all();
        setdiv(0, 4);
        checks++;
        if (pending[0] !== 1'b0) begin
            failures++;
            $display("FAIL n4_applied pending=%b expected 0", pending[0]);
        end
        set_en(0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            push_step();
            cyc();
            e = sbq.pop_front();
            checks++;
            if (clk_out !== e.co || tick !== e.tk) begin
                failures++;
                $display("FAIL n4 k=%0d clk_out=%b tick=%b expected %b %b", k, clk_out, tick, e.co, e.tk);
            end
        end
        set_en(0, 1'b0);
        cyc();
        checks++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            failures++;
            $display("FAIL en_low clk_out=%b tick=%b expected 0 0", clk_out[0], tick[0]);
        end
    endtask

    task automatic test_edge_divisors();
        exp_t e;
        int   nlist[3];
        nlist = '{5, 1, 0};
        foreach (nlist[j]) begin
            disable_all();
            setdiv(0, nlist[j]);
            set_en(0, 1'b1);
            for (int k = 0; k < 10; k++) begin
                push_step();
                cyc();
                e = sbq.pop_front();
                checks++;
                if (clk_out !== e.co || tick !== e.tk) begin
                    failures++;
                    $display("FAIL div%0d k=%0d clk_out=%b tick=%b expected %b %b",
                             nlist[j], k, clk_out, tick, e.co, e.tk);
                end
            end
        end
        // Channel is enabled but parked at N=0: a new divisor applies right away.
        setdiv(0, 4);
        checks++;
        if (pending[0] !== 1'b0) begin
            failures++;
            $display("FAIL div0_apply pending=%b expected 0", pending[0]);
        end
        for (int k = 0; k < 8; k++) begin
            push_step();
            cyc();
            e = sbq.pop_front();
            checks++;
            if (clk_out !== e.co || tick !== e.tk) begin
                failures++;
                $display("FAIL div0_to4 k=%0d clk_out=%b tick=%b expected %b %b", k, clk_out, tick, e.co, e.tk);
            end
        end
    endtask

    task automatic test_mid_period_update();
        exp_t e;
        disable_all();
        setdiv(0, 4);
        set_en(0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k == 2) begin
                checks++;
                if (cfg_if.cfg_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL mid_ready1 cfg_ready=%b expected 1", cfg_if.cfg_ready);
                end
                cfg_if.cfg_ch    = CH_W'(0);
                cfg_if.cfg_div   = DIV_W'(6);
                cfg_if.cfg_valid = 1'b1;
            end
            if (k == 3) begin
                cfg_if.cfg_div = DIV_W'(9);
                #1;
                checks++;
                if (pending[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL mid_pending pending=%b expected 1", pending[0]);
                end
                checks++;
                if (cfg_if.cfg_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_ready0 cfg_ready=%b expected 0", cfg_if.cfg_ready);
                end
            end
            if (k == 4) begin
                cfg_if.cfg_valid = 1'b0;
                checks++;
                if (pending[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_cleared pending=%b expected 0", pending[0]);
                end
            end
            push_step();
            if (k == 3) div_m[0] = 6;
            cyc();
            e = sbq.pop_front();
            checks++;
            if (clk_out !== e.co || tick !== e.tk) begin
                failures++;
                $display("FAIL mid k=%0d clk_out=%b tick=%b expected %b %b", k, clk_out, tick, e.co, e.tk);
            end
        end
    endtask

    task automatic test_wrap_transfer();
        exp_t e;
        disable_all();
        setdiv(0, 4);
        set_en(0, 1'b1);
        for (int k = 0; k < 14; k++) begin
            if (k == 3) begin
                cfg_if.cfg_ch    = CH_W'(0);
                cfg_if.cfg_div   = DIV_W'(2);
                cfg_if.cfg_valid = 1'b1;
            end
            if (k == 4) begin
                cfg_if.cfg_valid = 1'b0;
                checks++;
                if (pending[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_pending pending=%b expected 1", pending[0]);
                end
            end
            if (k == 8) begin
                checks++;
                if (pending[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_cleared pending=%b expected 0", pending[0]);
                end
            end
            push_step();
            if (k == 7) div_m[0] = 2;
            cyc();
            e = sbq.pop_front();
            checks++;
            if (clk_out !== e.co || tick !== e.tk) begin
                failures++;
                $display("FAIL wrap k=%0d clk_out=%b tick=%b expected %b %b", k, clk_out, tick, e.co, e.tk);
            end
        end
    endtask

    task automatic test_reset_pending();
        exp_t e;
        cfg_if.cfg_ch    = CH_W'(0);
        cfg_if.cfg_div   = DIV_W'(3);
        cfg_if.cfg_valid = 1'b1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        checks++;
        if (pending[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstp_staged pending=%b expected 1", pending[0]);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000 || pending !== 3'b000) begin
            failures++;
            $display("FAIL rstp_clear clk_out=%b tick=%b pending=%b expected 000 000 000",
                     clk_out, tick, pending);
        end
        for (int i = 0; i < NCH; i++) begin
            div_m[i] = DEF_DIV;
            ph_m[i]  = 0;
        end
        for (int k = 0; k < 14; k++) begin
            push_step();
            cyc();
            e = sbq.pop_front();
            checks++;
            if (clk_out !== e.co || tick !== e.tk) begin
                failures++;
                $display("FAIL rstp_default k=%0d clk_out=%b tick=%b expected %b %b", k, clk_out, tick, e.co, e.tk);
            end
        end
    endtask

    task automatic test_multi_channel();
        exp_t e;
        disable_all();
        setdiv(1, 3);
        setdiv(2, 2);
        for (int i = 0; i < NCH; i++) set_en(i, 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k == 6) set_en(1, 1'b0);
            if (k == 9) set_en(1, 1'b1);
            push_step();
            cyc();
            e = sbq.pop_front();
            checks++;
            if (clk_out !== e.co || tick !== e.tk) begin
                failures++;
                $display("FAIL multi k=%0d clk_out=%b tick=%b expected %b %b", k, clk_out, tick, e.co, e.tk);
            end
        end
    endtask

`ifdef CLKDIV_SYNC_START_EN
    task automatic test_sync_start();
        exp_t e;
        disable_all();
        setdiv(0, 4);
        setdiv(1, 6);
        set_en(0, 1'b1);
        for (int k = 0; k < 24; k++) begin
            if (k == 3) set_en(1, 1'b1);
            if (k == 5) begin
                cfg_if.cfg_ch    = CH_W'(1);
                cfg_if.cfg_div   = DIV_W'(8);
                cfg_if.cfg_valid = 1'b1;
            end
            if (k == 6) cfg_if.cfg_valid = 1'b0;
            if (k == 7) sync_start = 1'b1;
            if (k == 8) begin
                sync_start = 1'b0;
                checks++;
                if (pending[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL sync_apply pending=%b expected 0", pending[1]);
                end
            end
            push_step();
            if (k == 7) begin
                ph_m[0]  = 0;
                ph_m[1]  = 0;
                div_m[1] = 8;
            end
            cyc();
            e = sbq.pop_front();
            checks++;
            if (clk_out !== e.co || tick !== e.tk) begin
                failures++;
                $display("FAIL sync k=%0d clk_out=%b tick=%b expected %b %b", k, clk_out, tick, e.co, e.tk);
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        en               = '0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
`ifdef CLKDIV_SYNC_START_EN
        sync_start       = 1'b0;
`endif
        test_reset();
        test_cfg_boundary();
        test_basic_n4();
        test_edge_divisors();
        test_mid_period_update();
        test_wrap_transfer();
        test_reset_pending();
        test_multi_channel();
`ifdef CLKDIV_SYNC_START_EN
        test_sync_start();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
